// File: rtl/exec_sched_pkg.sv
// Shared definitions for the execution-unit scheduler: func codes, the
// per-unit state enum and the round-robin ready-entry picker.
package exec_sched_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } unit_state_t;

  // First set bit of req[n-1:0] at or after start, wrapping; 0 when none set.
  function automatic logic [4:0] rr_pick(input logic [31:0] req, input int n, input int start);
    logic [4:0] pick;
    logic       found;
    int         j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && !found) begin
        j = (start + i) % n;
        if (req[j[4:0]]) begin
          pick  = 5'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fu_sequencer.sv
// One functional-unit sequencer: picks a ready RS entry round-robin, times the
// unit latency, holds the finished result until the CDB arbiter grants it.
// The unit requests the bus already in its last execute cycle, so a result
// granted at once goes straight from EXEC back to IDLE.
module fu_sequencer
  import exec_sched_pkg::*;
#(
  parameter int         RS     = 3,
  parameter int         TAG_W  = 4,
  parameter int         DATA_W = 16,
  parameter logic [3:0] FUNC_A = FUNC_ADD,
  parameter int         LAT_A  = 4,
  parameter logic [3:0] FUNC_B = FUNC_SUB,
  parameter int         LAT_B  = 4,
  localparam int        IDX_W  = (RS > 1) ? $clog2(RS) : 1
) (
  input  logic                clock1,
  input  logic                reset,
  input  logic [RS-1:0]       rs_ready,
  input  logic [RS-1:0]       rs_mask,
  input  logic [4*RS-1:0]     rs_func,
  input  logic [TAG_W*RS-1:0] rs_dest,
  input  logic [DATA_W-1:0]   fu_result,
  input  logic                grant,
  output logic                issue,
  output logic [IDX_W-1:0]    issue_idx,
  output logic                busy,
  output logic                req,
  output logic [TAG_W-1:0]    req_tag,
  output logic [DATA_W-1:0]   req_data,
  output logic                req_err
);

  localparam int MAX_LAT = (LAT_A > LAT_B) ? LAT_A : LAT_B;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  unit_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  rr_reg, rr_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              issue_reg, issue_next;

  logic [RS-1:0]     avail;
  logic [IDX_W-1:0]  pick_idx;
  logic [3:0]        pick_func;
  logic              pick_legal;
  int                pick_lat;
  logic [IDX_W-1:0]  rr_wrap;
  logic [DATA_W-1:0] exec_data;

  assign avail      = rs_ready & ~rs_mask;
  assign pick_idx   = IDX_W'(rr_pick(32'(avail), RS, int'(rr_reg)));
  assign pick_func  = rs_func[4*pick_idx +: 4];
  assign pick_legal = (pick_func == FUNC_A) || (pick_func == FUNC_B);
  assign pick_lat   = (pick_func == FUNC_A) ? LAT_A : (pick_func == FUNC_B) ? LAT_B : 1;
  assign rr_wrap    = (idx_reg == IDX_W'(RS - 1)) ? '0 : idx_reg + 1'b1;
  // Illegal ops broadcast zero data regardless of what the unit produced.
  assign exec_data  = err_reg ? '0 : fu_result;

  // State register.
  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Datapath registers for the op currently owned by this unit.
  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      rr_reg     <= '0;
      tag_reg    <= '0;
      err_reg    <= 1'b0;
      result_reg <= '0;
      issue_reg  <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      rr_reg     <= rr_next;
      tag_reg    <= tag_next;
      err_reg    <= err_next;
      result_reg <= result_next;
      issue_reg  <= issue_next;
    end
  end

  // Next-state: select, count down, then wait for the bus grant.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    rr_next     = rr_reg;
    tag_next    = tag_reg;
    err_next    = err_reg;
    result_next = result_reg;
    issue_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|avail) begin
          state_next = EXEC;
          idx_next   = pick_idx;
          tag_next   = rs_dest[TAG_W*pick_idx +: TAG_W];
          err_next   = !pick_legal;
          cnt_next   = CNT_W'(pick_lat - 1);
          issue_next = 1'b1;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          if (grant) begin
            state_next = IDLE;
            rr_next    = rr_wrap;
          end else begin
            state_next  = DONE;
            result_next = exec_data;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        if (grant) begin
          state_next = IDLE;
          rr_next    = rr_wrap;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign issue     = issue_reg;
  assign issue_idx = idx_reg;
  assign busy      = (state_reg != IDLE);
  assign req       = ((state_reg == EXEC) && (cnt_reg == '0)) || (state_reg == DONE);
  assign req_tag   = tag_reg;
  assign req_err   = err_reg;
  assign req_data  = (state_reg == DONE) ? result_reg : exec_data;

endmodule

// File: rtl/exec_dispatch_ctrl.sv
// Dispatch controller: two unit sequencers (add/sub, mul/div) sharing one
// registered common data bus with alternating priority on contention.
// Optional build macro EXEC_PERF_EN adds saturating performance counters;
// without it the perf_* outputs are constant zero.
module exec_dispatch_ctrl
  import exec_sched_pkg::*;
#(
  parameter int  ADD_RS    = 3,
  parameter int  MUL_RS    = 3,
  parameter int  TAG_W     = 4,
  parameter int  DATA_W    = 16,
  parameter int  ADD_LAT   = 4,
  parameter int  MUL_LAT   = 6,
  parameter int  DIV_LAT   = 8,
  localparam int ADD_IDX_W = (ADD_RS > 1) ? $clog2(ADD_RS) : 1,
  localparam int MUL_IDX_W = (MUL_RS > 1) ? $clog2(MUL_RS) : 1
) (
  input  logic                    clock1,
  input  logic                    reset,
  input  logic [ADD_RS-1:0]       add_rs_ready,
  input  logic [4*ADD_RS-1:0]     add_rs_func,
  input  logic [TAG_W*ADD_RS-1:0] add_rs_dest,
  input  logic [MUL_RS-1:0]       mul_rs_ready,
  input  logic [4*MUL_RS-1:0]     mul_rs_func,
  input  logic [TAG_W*MUL_RS-1:0] mul_rs_dest,
  input  logic [DATA_W-1:0]       add_fu_result,
  input  logic [DATA_W-1:0]       mul_fu_result,
  output logic                    add_issue,
  output logic [ADD_IDX_W-1:0]    add_issue_idx,
  output logic                    mul_issue,
  output logic [MUL_IDX_W-1:0]    mul_issue_idx,
  output logic                    add_busy,
  output logic                    mul_busy,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    cdb_err,
  output logic [ADD_RS-1:0]       add_rs_release,
  output logic [MUL_RS-1:0]       mul_rs_release,
  output logic [15:0]             perf_add_ops,
  output logic [15:0]             perf_mul_ops,
  output logic [15:0]             perf_cdb_stall
);

  logic              add_req, mul_req, add_err, mul_err;
  logic [TAG_W-1:0]  add_tag, mul_tag;
  logic [DATA_W-1:0] add_data, mul_data;
  logic              grant_add, grant_mul;
  logic              last_grant_mul_reg;

  fu_sequencer #(
    .RS(ADD_RS), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .FUNC_A(FUNC_ADD), .LAT_A(ADD_LAT), .FUNC_B(FUNC_SUB), .LAT_B(ADD_LAT)
  ) u_add_seq (
    .clock1(clock1), .reset(reset),
    .rs_ready(add_rs_ready), .rs_mask(add_rs_release),
    .rs_func(add_rs_func), .rs_dest(add_rs_dest),
    .fu_result(add_fu_result), .grant(grant_add),
    .issue(add_issue), .issue_idx(add_issue_idx), .busy(add_busy),
    .req(add_req), .req_tag(add_tag), .req_data(add_data), .req_err(add_err)
  );

  fu_sequencer #(
    .RS(MUL_RS), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .FUNC_A(FUNC_MUL), .LAT_A(MUL_LAT), .FUNC_B(FUNC_DIV), .LAT_B(DIV_LAT)
  ) u_mul_seq (
    .clock1(clock1), .reset(reset),
    .rs_ready(mul_rs_ready), .rs_mask(mul_rs_release),
    .rs_func(mul_rs_func), .rs_dest(mul_rs_dest),
    .fu_result(mul_fu_result), .grant(grant_mul),
    .issue(mul_issue), .issue_idx(mul_issue_idx), .busy(mul_busy),
    .req(mul_req), .req_tag(mul_tag), .req_data(mul_data), .req_err(mul_err)
  );

  // On contention the unit that did not win last time gets the bus.
  assign grant_add = add_req && (!mul_req || last_grant_mul_reg);
  assign grant_mul = mul_req && !grant_add;

  // Registered CDB broadcast and matching RS release pulse.
  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) begin
      cdb_valid          <= 1'b0;
      cdb_tag            <= '0;
      cdb_data           <= '0;
      cdb_err            <= 1'b0;
      add_rs_release     <= '0;
      mul_rs_release     <= '0;
      last_grant_mul_reg <= 1'b1;
    end else begin
      cdb_valid      <= grant_add || grant_mul;
      add_rs_release <= grant_add ? (ADD_RS'(1) << add_issue_idx) : '0;
      mul_rs_release <= grant_mul ? (MUL_RS'(1) << mul_issue_idx) : '0;
      if (grant_add) begin
        cdb_tag            <= add_tag;
        cdb_data           <= add_data;
        cdb_err            <= add_err;
        last_grant_mul_reg <= 1'b0;
      end else if (grant_mul) begin
        cdb_tag            <= mul_tag;
        cdb_data           <= mul_data;
        cdb_err            <= mul_err;
        last_grant_mul_reg <= 1'b1;
      end else begin
        cdb_tag  <= '0;
        cdb_data <= '0;
        cdb_err  <= 1'b0;
      end
    end
  end

`ifdef EXEC_PERF_EN
  // Saturating counters: issue pulses per unit, cycles with both units holding a finished result.
  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) begin
      perf_add_ops   <= '0;
      perf_mul_ops   <= '0;
      perf_cdb_stall <= '0;
    end else begin
      if (add_issue && perf_add_ops != 16'hFFFF)              perf_add_ops   <= perf_add_ops + 16'd1;
      if (mul_issue && perf_mul_ops != 16'hFFFF)              perf_mul_ops   <= perf_mul_ops + 16'd1;
      if (add_req && mul_req && perf_cdb_stall != 16'hFFFF)   perf_cdb_stall <= perf_cdb_stall + 16'd1;
    end
  end
`else
  assign perf_add_ops   = '0;
  assign perf_mul_ops   = '0;
  assign perf_cdb_stall = '0;
`endif

endmodule
